lisp_program_loader: RTL

- Host-side front end for the Lisp core. It receives a framed byte stream, writes the program image into core memory starting at address 0, drives the start expression, and pulses start.
- It then waits for the core to halt or report an error, and streams a 3-byte result frame back.
- It sits between the byte transport (UART RX/TX wrappers) and the core's memory write port and start/status signals.
- It replaces hierarchical memory preloading with a synthesizable load/run/report path.

---
 rtl/lisp_program_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lisp_program_loader.sv
// Host-side loader for the Lisp core: receives a framed program image, writes it into
// core memory, starts the core, waits for halt/error/timeout and returns a 3-byte result.
module lisp_program_loader #(
  parameter int MemorySize    = 256,
  parameter int AddrWidth     = 8,
  parameter int TimeoutCycles = 1048576
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [15:0]          mem_wdata,
  output logic                 mem_we,
  output logic [15:0]          expr,
  output logic                 core_start,
  input  logic                 core_halted,
  input  logic                 core_error,
  input  logic [15:0]          core_val,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy
);

  localparam int                  CntWidth    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [8:0]          MemSizeC    = 9'(MemorySize);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

  localparam logic [7:0] HeaderByte   = 8'hA5;
  localparam logic [7:0] StatusOk     = 8'h00;
  localparam logic [7:0] StatusError  = 8'hEE;
  localparam logic [7:0] StatusSize   = 8'hE1;
  localparam logic [7:0] StatusTimer  = 8'hE2;

  typedef enum logic [3:0] {
    S_IDLE, S_COUNT, S_DATA_HI, S_DATA_LO, S_EXPR_HI, S_EXPR_LO, S_START, S_WAIT, S_SEND
  } state_t;

  state_t              state, state_next;
  logic [7:0]          n_words;
  logic [8:0]          index;
  logic [7:0]          hi_byte;
  logic [7:0]          status;
  logic [15:0]         payload;
  logic [1:0]          tx_idx;
  logic [CntWidth-1:0] timer;

  logic       rx_fire, tx_fire, oversize, timed_out;
  logic [8:0] index_next;

  assign rx_fire    = rx_valid && rx_ready;
  assign tx_fire    = tx_valid && tx_ready;
  assign oversize   = {1'b0, rx_data} > MemSizeC;
  assign timed_out  = (timer == TimeoutLast);
  assign index_next = index + 9'd1;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    core_start = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    busy       = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid && rx_data == HeaderByte) state_next = S_COUNT;
      end
      S_COUNT: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (oversize)              state_next = S_SEND;
          else if (rx_data == 8'h00) state_next = S_EXPR_HI;
          else                       state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = (index_next == {1'b0, n_words}) ? S_EXPR_HI : S_DATA_HI;
      end
      S_EXPR_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = S_EXPR_LO;
      end
      S_EXPR_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = S_START;
      end
      S_START: begin
        core_start = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (core_error || core_halted || timed_out) state_next = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        case (tx_idx)
          2'd0:    tx_data = status;
          2'd1:    tx_data = payload[15:8];
          default: tx_data = payload[7:0];
        endcase
        if (tx_ready && tx_idx == 2'd2) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_words   <= 8'h00;
      index     <= 9'd0;
      hi_byte   <= 8'h00;
      status    <= 8'h00;
      payload   <= 16'h0000;
      tx_idx    <= 2'd0;
      timer     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 16'h0000;
      expr      <= 16'h0000;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_COUNT: if (rx_fire) begin
          n_words <= rx_data;
          index   <= 9'd0;
          tx_idx  <= 2'd0;
          if (oversize) begin
            status  <= StatusSize;
            payload <= {8'h00, rx_data};
          end
        end
        S_DATA_HI: if (rx_fire) hi_byte <= rx_data;
        S_DATA_LO: if (rx_fire) begin
          mem_we    <= 1'b1;
          mem_addr  <= AddrWidth'(index);
          mem_wdata <= {hi_byte, rx_data};
          index     <= index_next;
        end
        S_EXPR_HI: if (rx_fire) hi_byte <= rx_data;
        // expr changes only here, so it stays stable from Start until the next frame
        S_EXPR_LO: if (rx_fire) expr <= {hi_byte, rx_data};
        S_START:   timer <= '0;
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (core_error) begin
            status  <= StatusError;
            payload <= core_val;
          end else if (core_halted) begin
            status  <= StatusOk;
            payload <= core_val;
          end else if (timed_out) begin
            status  <= StatusTimer;
            payload <= 16'h0000;
          end
        end
        S_SEND: if (tx_fire) tx_idx <= tx_idx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
